// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the decoded control bundle and operands once per cycle,
// injects a bubble on flush, holds on a downstream stall and counts injected bubbles.
module id_ex_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             clr_cnt_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             Branch_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [9:0]       funct_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic [4:0]       rd_addr_i,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             Branch_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [9:0]       funct_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic [4:0]       rd_addr_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic [1:0]      aluOp;
    logic            aluSrc;
    logic            regWrite;
    logic            memtoReg;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [9:0]      funct;
    logic [4:0]      rs1Addr;
    logic [4:0]      rs2Addr;
    logic [4:0]      rdAddr;
    logic            valid;
  } exBundle_t;

  exBundle_t        idBundle;
  exBundle_t        ex_d, ex_q;
  logic [CNT_W-1:0] bubbleCnt_d, bubbleCnt_q;

  always_comb begin
    idBundle = '{
      aluOp:    ALUOp_i,
      aluSrc:   ALUSrc_i,
      regWrite: RegWrite_i,
      memtoReg: MemtoReg_i,
      memRead:  MemRead_i,
      memWrite: MemWrite_i,
      branch:   Branch_i,
      pc:       pc_i,
      rs1Data:  rs1_data_i,
      rs2Data:  rs2_data_i,
      imm:      imm_i,
      funct:    funct_i,
      rs1Addr:  rs1_addr_i,
      rs2Addr:  rs2_addr_i,
      rdAddr:   rd_addr_i,
      valid:    1'b1
    };
  end

  // A bubble is the all-zero bundle, so it can never write, store or branch.
  always_comb begin
    ex_d        = ex_q;
    bubbleCnt_d = bubbleCnt_q;
    if (start_i) begin
      if (!hold_i) begin
        ex_d = flush_i ? '0 : idBundle;
      end
      if (clr_cnt_i) begin
        bubbleCnt_d = '0;
      end else if (!hold_i && flush_i && (bubbleCnt_q != '1)) begin
        bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q        <= '0;
      bubbleCnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign ALUOp_o      = ex_q.aluOp;
  assign ALUSrc_o     = ex_q.aluSrc;
  assign RegWrite_o   = ex_q.regWrite;
  assign MemtoReg_o   = ex_q.memtoReg;
  assign MemRead_o    = ex_q.memRead;
  assign MemWrite_o   = ex_q.memWrite;
  assign Branch_o     = ex_q.branch;
  assign pc_o         = ex_q.pc;
  assign rs1_data_o   = ex_q.rs1Data;
  assign rs2_data_o   = ex_q.rs2Data;
  assign imm_o        = ex_q.imm;
  assign funct_o      = ex_q.funct;
  assign rs1_addr_o   = ex_q.rs1Addr;
  assign rs2_addr_o   = ex_q.rs2Addr;
  assign rd_addr_o    = ex_q.rdAddr;
  assign valid_o      = ex_q.valid;
  assign bubble_cnt_o = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a slot-level model of what EX must hold, compared every
// falling edge, plus hand-computed literal checks at key points of a directed sequence.
module tb_id_ex_reg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int          CntMax = 15;

  typedef struct packed {
    logic [1:0]      aluOp;
    logic            aluSrc;
    logic            regWrite;
    logic            memtoReg;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [9:0]      funct;
    logic [4:0]      rs1Addr;
    logic [4:0]      rs2Addr;
    logic [4:0]      rdAddr;
    logic            valid;
  } slot_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic start_i, hold_i, flush_i, clr_cnt_i;
  slot_t drv;

  logic [1:0]       ALUOp_o;
  logic             ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o;
  logic [XLEN-1:0]  pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]       funct_o;
  logic [4:0]       rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic             valid_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  int nVec = 0;
  int nErr = 0;

  slot_t expSlot = '0;
  int    expCnt  = 0;
  slot_t actSlot;

  always #5 clk_i = ~clk_i;

  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .clr_cnt_i   (clr_cnt_i),
    .ALUOp_i     (drv.aluOp),
    .ALUSrc_i    (drv.aluSrc),
    .RegWrite_i  (drv.regWrite),
    .MemtoReg_i  (drv.memtoReg),
    .MemRead_i   (drv.memRead),
    .MemWrite_i  (drv.memWrite),
    .Branch_i    (drv.branch),
    .pc_i        (drv.pc),
    .rs1_data_i  (drv.rs1Data),
    .rs2_data_i  (drv.rs2Data),
    .imm_i       (drv.imm),
    .funct_i     (drv.funct),
    .rs1_addr_i  (drv.rs1Addr),
    .rs2_addr_i  (drv.rs2Addr),
    .rd_addr_i   (drv.rdAddr),
    .ALUOp_o     (ALUOp_o),
    .ALUSrc_o    (ALUSrc_o),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .MemRead_o   (MemRead_o),
    .MemWrite_o  (MemWrite_o),
    .Branch_o    (Branch_o),
    .pc_o        (pc_o),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .imm_o       (imm_o),
    .funct_o     (funct_o),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rd_addr_o   (rd_addr_o),
    .valid_o     (valid_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always_comb begin
    actSlot = '{
      aluOp: ALUOp_o, aluSrc: ALUSrc_o, regWrite: RegWrite_o, memtoReg: MemtoReg_o,
      memRead: MemRead_o, memWrite: MemWrite_o, branch: Branch_o, pc: pc_o,
      rs1Data: rs1_data_o, rs2Data: rs2_data_o, imm: imm_o, funct: funct_o,
      rs1Addr: rs1_addr_o, rs2Addr: rs2_addr_o, rdAddr: rd_addr_o, valid: valid_o
    };
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: EX holds whichever instruction last got past the gate, a bubble being an empty slot.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      expSlot = '0;
      expCnt  = 0;
    end else if (start_i) begin
      if (!hold_i) begin
        if (flush_i) begin
          expSlot = '0;
        end else begin
          expSlot       = drv;
          expSlot.valid = 1'b1;
        end
      end
      if (clr_cnt_i)             expCnt = 0;
      else if (!hold_i && flush_i) expCnt = (expCnt < CntMax) ? expCnt + 1 : CntMax;
    end
  end

  always @(negedge clk_i) begin
    chk("slot", 256'(actSlot), 256'(expSlot));
    chk("bubble_cnt", 256'(bubble_cnt_o), 256'(expCnt));
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  slot_t frozen;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;
    drv = '0;
    #1 rst_i = 1'b0;
    repeat (2) cyc();
    rst_i = 1'b1;
    start_i = 1'b1;

    // lw x5, 16(x2)
    drv = '{aluOp: 2'b00, aluSrc: 1'b1, regWrite: 1'b1, memtoReg: 1'b1, memRead: 1'b1,
            memWrite: 1'b0, branch: 1'b0, pc: 32'h0000_0100, rs1Data: 32'h0000_2000,
            rs2Data: 32'h0, imm: 32'h10, funct: 10'b000_0000_010, rs1Addr: 5'd2,
            rs2Addr: 5'd0, rdAddr: 5'd5, valid: 1'b0};
    cyc();
    chk("lw pc", 256'(pc_o), 256'(32'h100));
    chk("lw ctrl", 256'({ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                         Branch_o}), 256'(8'b00_1111_00));
    chk("lw imm", 256'(imm_o), 256'(32'h10));
    chk("lw rd", 256'(rd_addr_o), 256'(5));
    chk("lw valid", 256'(valid_o), 256'(1));

    // beq under flush becomes a bubble
    drv = '{aluOp: 2'b01, aluSrc: 1'b0, regWrite: 1'b0, memtoReg: 1'b0, memRead: 1'b0,
            memWrite: 1'b0, branch: 1'b1, pc: 32'h104, rs1Data: 32'h7, rs2Data: 32'h7,
            imm: 32'hFFFF_FFF8, funct: 10'b000_0000_000, rs1Addr: 5'd6, rs2Addr: 5'd7,
            rdAddr: 5'd8, valid: 1'b0};
    flush_i = 1'b1;
    cyc();
    chk("flush ctrl", 256'({ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                            Branch_o}), 256'(0));
    chk("flush rd", 256'(rd_addr_o), 256'(0));
    chk("flush valid", 256'(valid_o), 256'(0));
    chk("flush cnt", 256'(bubble_cnt_o), 256'(1));

    // add x3, x1, x2 then hold+flush for 3 cycles
    drv = '{aluOp: 2'b10, aluSrc: 1'b0, regWrite: 1'b1, memtoReg: 1'b0, memRead: 1'b0,
            memWrite: 1'b0, branch: 1'b0, pc: 32'h108, rs1Data: 32'h11, rs2Data: 32'h22,
            imm: 32'h0, funct: 10'b000_0000_000, rs1Addr: 5'd1, rs2Addr: 5'd2,
            rdAddr: 5'd3, valid: 1'b0};
    flush_i = 1'b0;
    cyc();
    hold_i = 1'b1; flush_i = 1'b1;
    drv.pc = 32'h10C; drv.rdAddr = 5'd9;
    repeat (3) cyc();
    chk("hold rd", 256'(rd_addr_o), 256'(3));
    chk("hold pc", 256'(pc_o), 256'(32'h108));
    chk("hold valid", 256'(valid_o), 256'(1));
    chk("hold cnt", 256'(bubble_cnt_o), 256'(1));
    hold_i = 1'b0;
    cyc();
    chk("unhold valid", 256'(valid_o), 256'(0));
    chk("unhold cnt", 256'(bubble_cnt_o), 256'(2));

    // saturation then clear
    repeat (20) cyc();
    chk("sat cnt", 256'(bubble_cnt_o), 256'(15));
    clr_cnt_i = 1'b1;
    cyc();
    chk("clr cnt", 256'(bubble_cnt_o), 256'(0));
    clr_cnt_i = 1'b0; flush_i = 1'b0;

    // rd = x0 with RegWrite passes through unchanged
    drv.regWrite = 1'b1; drv.rdAddr = 5'd0; drv.pc = 32'h200;
    cyc();
    chk("x0 regwrite", 256'({RegWrite_o, rd_addr_o, valid_o}), 256'(7'b1_00000_1));

    // start_i = 0 freezes everything
    flush_i = 1'b1;
    cyc();
    frozen = actSlot;
    start_i = 1'b0;
    drv.pc = 32'h300;
    for (int i = 0; i < 6; i++) begin
      hold_i = i[0]; flush_i = i[1]; clr_cnt_i = (i >= 3);
      cyc();
    end
    chk("freeze cnt", 256'(bubble_cnt_o), 256'(1));
    chk("freeze valid", 256'(valid_o), 256'(0));
    start_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;

    // back-to-back loads with varied data
    for (int i = 0; i < 8; i++) begin
      drv = '{aluOp: 2'(i), aluSrc: i[0], regWrite: i[1], memtoReg: i[2], memRead: ~i[0],
              memWrite: ~i[1], branch: ~i[2], pc: 32'h400 + 32'(4 * i),
              rs1Data: 32'hA5A5_0000 ^ 32'(i), rs2Data: 32'h5A5A_0000 + 32'(i),
              imm: 32'(i) << 8, funct: 10'(3 * i), rs1Addr: 5'(i), rs2Addr: 5'(31 - i),
              rdAddr: 5'(i + 10), valid: 1'b0};
      flush_i = (i == 5);
      cyc();
    end
    chk("b2b pc", 256'(pc_o), 256'(32'h41C));
    chk("b2b cnt", 256'(bubble_cnt_o), 256'(2));

    // asynchronous reset mid-operation
    flush_i = 1'b0; hold_i = 1'b1; clr_cnt_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    chk("async rst slot", 256'(actSlot), 256'(0));
    chk("async rst cnt", 256'(bubble_cnt_o), 256'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b1; hold_i = 1'b0; clr_cnt_i = 1'b0;
    drv.pc = 32'h40;
    cyc();
    chk("post rst pc", 256'(pc_o), 256'(32'h40));
    chk("post rst valid", 256'(valid_o), 256'(1));

    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
